// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-side front end for the 32x32 register file. Arbitrates two result
//   producers (A: single-cycle ALU, B: multi-cycle load/long-latency) onto the
//   file's single write port, registers the winning write one cycle ahead of
//   the file, and keeps a pending scoreboard so decode can stall on sources.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   a_valid/a_ready/a_rd/a_data   producer A handshake + payload
//   b_valid/b_ready/b_rd/b_data   producer B handshake + payload
//   issue_valid/issue_rd      decode issued a writer of issue_rd
//   ra/rb -> ra_busy/rb_busy  source-operand hazard queries
//   wr/rd/rd_d                registered register-file write port
//   pending                   scoreboard mask, bit 0 always 0
module regfile_writeback #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        ra_busy,
  output logic        rb_busy,
  output logic        wr,
  output logic [4:0]  rd,
  output logic [31:0] rd_d,
  output logic [31:0] pending
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        b_force, a_win, b_win, xfer;
  wb_req_t     win;
  logic [31:0] pend_q, set_mask, clr_mask;

  // B takes priority once it has lost LIM consecutive cycles.
  assign b_force = b_valid && (starve_cnt == LIM);
  assign b_win   = b_valid && (b_force || !a_valid);
  assign a_win   = a_valid && !b_force;
  assign a_ready = a_win;
  assign b_ready = b_win;
  assign xfer    = a_win || b_win;

  always_comb begin
    win.rd   = a_rd;
    win.data = a_data;
    if (b_win) begin
      win.rd   = b_rd;
      win.data = b_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (b_valid && !b_win)
      starve_cnt <= (starve_cnt == LIM) ? LIM : starve_cnt + 4'd1;
    else
      starve_cnt <= '0;
  end

  // Set is applied after clear so a same-cycle issue keeps the bit set:
  // a new producer is already in flight.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid) set_mask[issue_rd] = 1'b1;
    if (xfer)        clr_mask[win.rd]   = 1'b1;
    set_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= ((pend_q & ~clr_mask) | set_mask) & ~32'h1;
  end

  // Writes to x0 are consumed without touching the file; address/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr   <= 1'b0;
      rd   <= '0;
      rd_d <= '0;
    end else begin
      wr <= xfer && (win.rd != 5'd0);
      if (xfer && (win.rd != 5'd0)) begin
        rd   <= win.rd;
        rd_d <= win.data;
      end
    end
  end

  // The wr term covers the cycle where the scoreboard bit has already
  // cleared but the file has not yet captured the value.
  assign ra_busy = (ra != 5'd0) && (pend_q[ra] || (wr && (rd == ra)));
  assign rb_busy = (rb != 5'd0) && (pend_q[rb] || (wr && (rd == rb)));
  assign pending = pend_q;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 0, b_valid = 0, issue_valid = 0;
  logic [4:0]  a_rd = 0, b_rd = 0, issue_rd = 0, ra = 0, rb = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic        a_ready, b_ready, ra_busy, rb_busy, wr;
  logic [4:0]  rd;
  logic [31:0] rd_d, pending;

  regfile_writeback #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .ra(ra), .rb(rb), .ra_busy(ra_busy), .rb_busy(rb_busy),
    .wr(wr), .rd(rd), .rd_d(rd_d), .pending(pending)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // B's loss streak, the set of registers awaiting writeback, and the list
  // of accepted writes that must appear on the file port, in order.
  int           m_lost = 0;
  bit           m_pend [32];
  bit           m_wr = 0;
  logic [4:0]   m_rd = 0;
  logic [36:0]  exp_q[$];

  function automatic bit b_wins();
    return b_valid && (m_lost >= LIMIT || !a_valid);
  endfunction
  function automatic bit a_wins();
    return a_valid && !b_wins();
  endfunction
  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_clear();
    m_lost = 0;
    m_wr = 0;
    m_rd = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    exp_q.delete();
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (rst) model_clear();
      else begin
        bit bw, aw;
        logic [4:0] r;
        bw = b_wins();
        aw = a_wins();
        r = bw ? b_rd : a_rd;
        m_wr = 0;
        if ((aw || bw) && r != 0) begin
          m_pend[r] = 0;
          m_wr = 1;
          m_rd = r;
          exp_q.push_back({r, bw ? b_data : a_data});
        end
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        if (b_valid && !bw) m_lost = m_lost + 1;
        else m_lost = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("a_ready", a_ready, a_wins());
      chk("b_ready", b_ready, b_wins());
      chk("pending", pending, pend_vec());
      chk("wr", wr, m_wr);
      chk("ra_busy", ra_busy, (ra != 0) && (m_pend[ra] || (m_wr && m_rd == ra)));
      chk("rb_busy", rb_busy, (rb != 0) && (m_pend[rb] || (m_wr && m_rd == rb)));
      if (m_wr) begin
        if (exp_q.size() == 0) chk("wb_order_empty", 1, 0);
        else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("wb_rd", rd, e[36:32]);
          chk("wb_data", rd_d, e[31:0]);
        end
      end
    end
  end

  task automatic idle();
    a_valid = 0; b_valid = 0; issue_valid = 0;
    a_rd = 0; b_rd = 0; issue_rd = 0; a_data = 0; b_data = 0;
    ra = 0; rb = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + soak ----------------
  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_wr", wr, 0);
    chk("rst_pending", pending, 0);
    chk("rst_rd_d", rd_d, 0);

    // single write
    issue_valid = 1; issue_rd = 5;
    next();
    issue_valid = 0;
    chk("sw_pend5", pending, 32'h20);
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; ra = 5;
    #1 chk("sw_a_ready", a_ready, 1);
    chk("sw_busy_pre", ra_busy, 1);
    next();
    a_valid = 0;
    chk("sw_wr", wr, 1);
    chk("sw_rd", rd, 5);
    chk("sw_rd_d", rd_d, 32'hDEADBEEF);
    chk("sw_pend_clr", pending, 0);
    chk("sw_busy_wr", ra_busy, 1);
    next();
    chk("sw_wr_off", wr, 0);
    chk("sw_busy_off", ra_busy, 0);

    // priority and starvation: B wins on the 5th and 10th cycle
    for (int i = 0; i < 10; i++) begin
      a_valid = 1; a_rd = 5'd1; a_data = 32'h100 + i;
      b_valid = 1; b_rd = 5'd2; b_data = 32'h200 + i;
      #1;
      chk("st_a_ready", a_ready, (i != 4 && i != 9));
      chk("st_b_ready", b_ready, (i == 4 || i == 9));
      next();
    end
    a_valid = 0;
    #1 chk("st_b_alone", b_ready, 1);
    next();
    idle();
    next();

    // x0 handling
    issue_valid = 1; issue_rd = 0;
    a_valid = 1; a_rd = 0; a_data = 32'h1234; ra = 0;
    #1 chk("x0_a_ready", a_ready, 1);
    chk("x0_busy", ra_busy, 0);
    next();
    idle();
    chk("x0_wr", wr, 0);
    chk("x0_pending", pending, 0);

    // set/clear collision on r7
    issue_valid = 1; issue_rd = 7;
    b_valid = 1; b_rd = 7; b_data = 32'hCAFE0007;
    #1 chk("col_b_ready", b_ready, 1);
    next();
    idle();
    chk("col_wr", wr, 1);
    chk("col_rd", rd, 7);
    chk("col_rd_d", rd_d, 32'hCAFE0007);
    chk("col_pend7", pending, 32'h80);

    // async reset mid-operation with a write in flight
    issue_valid = 1; issue_rd = 8; a_valid = 1; a_rd = 7; a_data = 32'h77;
    next();
    idle();
    issue_valid = 1; issue_rd = 9;
    next();
    issue_rd = 10;
    next();
    issue_rd = 11; a_valid = 1; a_rd = 3; a_data = 32'h33;
    next();
    idle();
    chk("pre_rst_wr", wr, 1);
    chk("pre_rst_pend", pending, 32'h0000_0F00);
    #2 rst = 1;
    #1;
    chk("arst_wr", wr, 0);
    chk("arst_rd", rd, 0);
    chk("arst_rd_d", rd_d, 0);
    chk("arst_pend", pending, 0);
    model_clear();
    next();
    rst = 0;

    // randomized soak
    for (int i = 0; i < 400; i++) begin
      a_valid = ($urandom_range(0, 99) < 60);
      b_valid = ($urandom_range(0, 99) < 50);
      a_rd = 5'($urandom_range(0, 9));
      b_rd = 5'($urandom_range(0, 9));
      a_data = $urandom;
      b_data = $urandom;
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_rd = 5'($urandom_range(0, 9));
      ra = 5'($urandom_range(0, 9));
      rb = 5'($urandom_range(0, 31));
      next();
    end
    idle();
    repeat (3) next();
    chk("soak_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the core's 32×32 register file. It arbitrates result traffic from two producers onto the register file's single write port: port A is the single-cycle ALU path, port B is the multi-cycle load/long-latency path. It registers the winning write one cycle ahead of the file. It also keeps a 32-bit pending scoreboard, so decode can stall on a source register whose producer has not yet written back.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive cycles port B may be valid and lose arbitration before it takes priority; legal range 1–15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  port A holds a result
- a_ready  out  1  port A result accepted this cycle
- a_rd  in  5  port A destination register
- a_data  in  32  port A result value
- b_valid  in  1  port B holds a result
- b_ready  out  1  port B result accepted this cycle
- b_rd  in  5  port B destination register
- b_data  in  32  port B result value
- issue_valid  in  1  decode issued an instruction that will write issue_rd
- issue_rd  in  5  destination register of the issued instruction
- ra  in  5  source register A query
- rb  in  5  source register B query
- ra_busy  out  1  ra has an unwritten pending result
- rb_busy  out  1  rb has an unwritten pending result
- wr  out  1  register file write enable (registered)
- rd  out  5  register file write address (registered)
- rd_d  out  32  register file write data (registered)
- pending  out  32  scoreboard bitmask; bit i is set while register i awaits writeback

## Operation
- A transfer on a port occurs when valid and ready are both high at a rising edge. At most one port transfers per cycle.
- starve counter, 4 bits:
  - Increments when b_valid=1 and b_ready=0.
  - Clears when B transfers or when b_valid=0.
  - Saturates at STARVE_LIMIT.
- Arbitration is combinational from the valids and the counter:
  - If the counter equals STARVE_LIMIT and b_valid=1, B wins.
  - Otherwise, if a_valid=1, A wins.
  - Otherwise, if b_valid=1, B wins.
  - a_ready or b_ready is high only for the winner. Ready never depends on the register file, which never stalls.
- Output stage, updated at the edge of a transfer:
  - If the winner's rd is not 0: wr←1, rd←winner rd, rd_d←winner data.
  - If the winner's rd is 0: the transfer is consumed and wr←0; rd and rd_d hold.
  - With no transfer: wr←0; rd and rd_d hold their last values.
- Scoreboard, per bit i, at each edge:
  - Set if issue_valid=1 and issue_rd=i.
  - Cleared if a transfer with rd=i occurs.
  - If both happen in the same cycle, set wins, because a new producer is in flight.
  - pending[0] is hardwired to 0; issue_rd=0 is ignored.
- Busy flags (combinational):
  - ra_busy = (ra≠0) & (pending[ra] | (wr & rd==ra)).
  - rb_busy is the same with rb.
  - The wr term covers the cycle in which the scoreboard bit has cleared but the register file has not yet captured the value.
- Multiple issues to the same rd before writeback leave a single bit set. The first writeback clears it; ordering between producers is decode's responsibility.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - wr=0, rd=0, rd_d=0, pending=0, starve counter=0.
  - a_ready and b_ready follow the arbitration rule with the counter at 0.
- Reset asserted mid-operation discards any in-flight output write immediately (wr drops without waiting for a clock) and clears all pending bits.
- Latency:
  - Transfer at edge k → wr/rd/rd_d valid during cycle k→k+1 → register file updated at edge k+1.
  - Issue at edge k → pending and busy visible from edge k.
- Back-to-back transfers on consecutive edges produce wr=1 on consecutive cycles; throughput is one write per cycle.
- Starvation bound: with A valid every cycle, B with b_valid held transfers no later than STARVE_LIMIT+1 edges after raising b_valid.

## Test plan
- Reset: assert rst asynchronously mid-cycle with wr=1 and pending=0x0000_0F00 → wr, rd, rd_d and pending are 0 immediately, before any clock edge.
- Single write:
  - Issue rd=5, then transfer A with rd=5, data=0xDEADBEEF.
  - Required: pending[5]=1 after the issue edge; wr=1, rd=5, rd_d=0xDEADBEEF in the next cycle; pending[5]=0; ra=5 gives ra_busy=1 during the wr cycle and 0 after it.
- Priority and starvation, STARVE_LIMIT=4:
  - Drive A and B valid every cycle.
  - Required: A wins 4 cycles, B wins the 5th, and the counter returns to 0.
  - Then drive B alone → B wins immediately.
- x0 handling:
  - Issue rd=0 and transfer A with rd=0, data=0x1234.
  - Required: a_ready=1, wr stays 0, pending stays 0, and ra=0 gives ra_busy=0.
- Set/clear collision:
  - Issue rd=7 in the same cycle as a B transfer with rd=7.
  - Required: wr=1 with rd=7 next cycle, and pending[7] remains 1.
- Randomized soak:
  - Random valids, rds and issues against a reference scoreboard model.
  - Required: pending matches the model every cycle; every accepted non-zero-rd result appears exactly once on wr/rd/rd_d, in acceptance order.
